fsm_code_tx: RTL and testbench

Transmit-side companion to the 3-bit code-detecting state machine. It accepts level requests (set/clear) over a valid/ready handshake and drives the 3-bit `code` bus with the set code (3'b011) or clear code (3'b100). Each code is held for a programmable number of cycles, followed by an idle gap. The block keeps a mirror of the level the downstream detector now holds.

---
 rtl/fsm_code_pkg.sv | 20 ++
 rtl/fsm_code_tx_if.sv | 11 +
 rtl/code_hold_timer.sv | 28 ++
 rtl/fsm_code_tx.sv | 109 ++++++++++
 tb/tb_fsm_code_tx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fsm_code_pkg.sv
// Shared code-bus constants and state encodings for the code transmitter
// and the downstream 3-bit code detector.
package fsm_code_pkg;

    localparam logic [2:0] SET_CODE  = 3'b011;
    localparam logic [2:0] CLR_CODE  = 3'b100;
    localparam logic [2:0] IDLE_CODE = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Width of a counter that must hold values 0..max(hold, gap).
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fsm_code_tx_if.sv
// Level-request handshake between a requester and the code transmitter.
interface fsm_code_tx_if;

    logic req_valid;
    logic req_level;
    logic req_ready;

    modport master (output req_valid, output req_level, input  req_ready);
    modport slave  (input  req_valid, input  req_level, output req_ready);

endinterface

// File: rtl/code_hold_timer.sv
// Loadable down-counter with a zero flag; times both the HOLD and GAP phases.
module code_hold_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fsm_code_tx.sv
// Transmits set/clear codes to a 3-bit code detector: each code is held for
// HOLD_CYCLES, followed by GAP_CYCLES of idle code, and the detector level is mirrored.
module fsm_code_tx #(
    parameter int         HOLD_CYCLES    = 2,
    parameter int         GAP_CYCLES     = 1,
    parameter logic [2:0] SET_CODE       = fsm_code_pkg::SET_CODE,
    parameter logic [2:0] CLR_CODE       = fsm_code_pkg::CLR_CODE,
    parameter logic [2:0] IDLE_CODE      = fsm_code_pkg::IDLE_CODE,
    parameter bit         SKIP_REDUNDANT = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    fsm_code_tx_if.slave       req,
    output logic [2:0]         code,
    output logic               busy,
    output logic               level_mirror,
    output logic               done
);

    import fsm_code_pkg::ST_IDLE;
    import fsm_code_pkg::ST_HOLD;
    import fsm_code_pkg::ST_GAP;
    import fsm_code_pkg::cnt_width;

    localparam int             CW        = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic          cmd_level;
    logic          first_hold;
    logic          skip_done;
    logic          accept;
    logic          redundant;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_zero;

    assign req.req_ready = (state == ST_IDLE) && !reset;
    assign accept        = req.req_valid && req.req_ready;
    assign redundant     = SKIP_REDUNDANT && (req.req_level == level_mirror);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = HOLD_LOAD;
        if (state == ST_IDLE && accept && !redundant) begin
            tmr_load = 1'b1;
        end else if (state == ST_HOLD && tmr_zero && GAP_CYCLES > 0) begin
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
        end
    end

    code_hold_timer #(.WIDTH(CW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            code         <= IDLE_CODE;
            level_mirror <= 1'b0;
            cmd_level    <= 1'b0;
            first_hold   <= 1'b0;
            skip_done    <= 1'b0;
        end else begin
            skip_done  <= 1'b0;
            first_hold <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (redundant) begin
                            skip_done <= 1'b1;
                        end else begin
                            cmd_level  <= req.req_level;
                            first_hold <= 1'b1;
                            code       <= req.req_level ? SET_CODE : CLR_CODE;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // The detector samples the code on this same edge.
                    if (first_hold) level_mirror <= cmd_level;
                    if (tmr_zero) begin
                        code  <= IDLE_CODE;
                        state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = skip_done
                | (state == ST_GAP  && tmr_zero)
                | (state == ST_HOLD && tmr_zero && GAP_CYCLES == 0);

endmodule

// File: tb/tb_fsm_code_tx.sv
// Directed bench for fsm_code_tx: per-cycle vector table on the default
// configuration, a zero-gap back-to-back sequence, and a random level stream.
module tb_fsm_code_tx;

    logic clock;
    logic reset_a, reset_b;
    logic [2:0] code_a, code_b;
    logic busy_a, busy_b, mirror_a, mirror_b, done_a, done_b;
    logic det_a, det_b;

    int checks, errors;
    int n_acc, n_done;
    logic exp_level;

    fsm_code_tx_if ifa ();
    fsm_code_tx_if ifb ();

    fsm_code_tx dut_a (
        .clock(clock), .reset(reset_a), .req(ifa.slave),
        .code(code_a), .busy(busy_a), .level_mirror(mirror_a), .done(done_a)
    );

    fsm_code_tx #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset_b), .req(ifb.slave),
        .code(code_b), .busy(busy_b), .level_mirror(mirror_b), .done(done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference detector: set code -> 1, clear code -> 0, anything else holds.
    always @(posedge clock) begin
        if (reset_a)                det_a <= 1'b0;
        else if (code_a == 3'b011)  det_a <= 1'b1;
        else if (code_a == 3'b100)  det_a <= 1'b0;
        if (reset_b)                det_b <= 1'b0;
        else if (code_b == 3'b011)  det_b <= 1'b1;
        else if (code_b == 3'b100)  det_b <= 1'b0;
    end

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       level;
        logic [2:0] code;
        logic       busy;
        logic       done;
        logic       ready;
        logic       mirror;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    function automatic vec_t mk(input int r, input int va, input int l, input int c,
                                input int b, input int d, input int rd, input int m);
        vec_t v;
        v.rst = r[0]; v.valid = va[0]; v.level = l[0]; v.code = c[2:0];
        v.busy = b[0]; v.done = d[0]; v.ready = rd[0]; v.mirror = m[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_a();
        @(negedge clock);
        #1;
        if (done_a) n_done++;
        check("mirror_vs_detector", 32'(mirror_a), 32'(det_a));
    endtask

    logic [2:0] zg_code [10];
    logic [9:0] zg_busy, zg_done, zg_mirror;

    initial begin
        checks = 0; errors = 0; n_acc = 0; n_done = 0;
        reset_a = 1'b1; reset_b = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_level = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_level = 1'b0;

        //             rst v  l  code    busy done rdy mirror
        vecs[0]  = mk(1, 0, 0, 3'b000, 0, 0, 0, 0);  // in reset
        vecs[1]  = mk(1, 1, 1, 3'b000, 0, 0, 0, 0);  // no ready while reset
        vecs[2]  = mk(0, 0, 0, 3'b000, 0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 1, 3'b000, 0, 0, 1, 0);  // accept set
        vecs[4]  = mk(0, 0, 0, 3'b011, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 3'b011, 1, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 3'b000, 1, 1, 0, 1);  // gap + done
        vecs[7]  = mk(0, 0, 0, 3'b000, 0, 0, 1, 1);
        vecs[8]  = mk(0, 1, 1, 3'b000, 0, 0, 1, 1);  // redundant set
        vecs[9]  = mk(0, 1, 1, 3'b000, 0, 1, 1, 1);  // back-to-back redundant
        vecs[10] = mk(0, 0, 0, 3'b000, 0, 1, 1, 1);
        vecs[11] = mk(0, 0, 0, 3'b000, 0, 0, 1, 1);
        vecs[12] = mk(0, 1, 0, 3'b000, 0, 0, 1, 1);  // accept clear
        vecs[13] = mk(0, 1, 0, 3'b100, 1, 0, 0, 1);  // stalled, level wiggles
        vecs[14] = mk(0, 1, 1, 3'b100, 1, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 3'b000, 1, 1, 0, 0);
        vecs[16] = mk(0, 1, 1, 3'b000, 0, 0, 1, 0);  // accept set sampled here
        vecs[17] = mk(0, 0, 0, 3'b011, 1, 0, 0, 0);
        vecs[18] = mk(1, 0, 0, 3'b011, 1, 0, 0, 1);  // reset mid-hold
        vecs[19] = mk(0, 0, 0, 3'b000, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 3'b000, 0, 0, 1, 0);  // no done after abort
        vecs[21] = mk(0, 1, 1, 3'b000, 0, 0, 1, 0);  // next set proceeds
        vecs[22] = mk(0, 0, 0, 3'b011, 1, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 3'b011, 1, 0, 0, 1);
        vecs[24] = mk(0, 0, 0, 3'b000, 1, 1, 0, 1);
        vecs[25] = mk(0, 0, 0, 3'b000, 0, 0, 1, 1);
        vecs[26] = mk(0, 1, 0, 3'b000, 0, 0, 1, 1);  // accept clear
        vecs[27] = mk(0, 1, 0, 3'b100, 1, 0, 0, 1);
        vecs[28] = mk(0, 1, 0, 3'b100, 1, 0, 0, 0);
        vecs[29] = mk(0, 1, 0, 3'b000, 1, 1, 0, 0);
        vecs[30] = mk(0, 1, 0, 3'b000, 0, 0, 1, 0);  // redundant clear
        vecs[31] = mk(0, 0, 0, 3'b000, 0, 1, 1, 0);
        vecs[32] = mk(0, 0, 0, 3'b000, 0, 0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            reset_a       = vecs[i].rst;
            ifa.req_valid = vecs[i].valid;
            ifa.req_level = vecs[i].level;
            #1;
            check($sformatf("vec%0d", i),
                  32'({code_a, busy_a, done_a, ifa.req_ready, mirror_a}),
                  32'({vecs[i].code, vecs[i].busy, vecs[i].done, vecs[i].ready, vecs[i].mirror}));
        end
        ifa.req_valid = 1'b0;

        // Zero-gap, H=3, valid held high: set then clear, then a redundant clear.
        zg_code   = '{3'b000, 3'b011, 3'b011, 3'b011, 3'b000,
                      3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        zg_busy   = 10'b00_1110_1110;
        zg_done   = 10'b10_1000_1000;
        zg_mirror = 10'b00_0011_1100;
        @(negedge clock);
        reset_b = 1'b0; ifb.req_valid = 1'b1; ifb.req_level = 1'b1;
        #1;
        check("zg_ready_c0", 32'(ifb.req_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(negedge clock);
                if (c == 1) ifb.req_level = 1'b0;
                #1;
            end
            check($sformatf("zg_code_c%0d", c),   32'(code_b),   32'(zg_code[c]));
            check($sformatf("zg_busy_c%0d", c),   32'(busy_b),   32'(zg_busy[c]));
            check($sformatf("zg_done_c%0d", c),   32'(done_b),   32'(zg_done[c]));
            check($sformatf("zg_mirror_c%0d", c), 32'(mirror_b), 32'(zg_mirror[c]));
            check($sformatf("zg_det_c%0d", c),    32'(det_b),    32'(mirror_b));
        end
        ifb.req_valid = 1'b0;
        check("zg_det_final", 32'(det_b), 32'd0);

        // Random level stream on the default configuration.
        @(negedge clock);
        #1;
        n_acc = 0; n_done = 0; exp_level = mirror_a;
        for (int r = 0; r < 500; r++) begin
            int waited;
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            ifa.req_valid = 1'b1;
            ifa.req_level = lvl;
            waited = 0;
            while (!ifa.req_ready && waited < 10) begin
                tick_a();
                waited++;
            end
            check("rand_ready_within_budget", 32'(ifa.req_ready), 32'd1);
            if (ifa.req_ready) begin
                n_acc++;
                exp_level = lvl;
            end
            tick_a();
            if ($urandom_range(0, 1) == 0) begin
                ifa.req_valid = 1'b0;
                tick_a();
            end
        end
        ifa.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick_a();
        check("rand_done_count", 32'(n_done), 32'(n_acc));
        check("rand_final_mirror", 32'(mirror_a), 32'(exp_level));
        check("rand_final_idle", 32'({busy_a, code_a}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
